// File: rtl/counter_pkg.sv
// Shared encodings for updown_mode_counter: count-mode selects and BCD digit limit.
package counter_pkg;

    localparam int unsigned NIBBLE_W = 4;

    localparam logic [1:0] MODE_BIN = 2'd0;
    localparam logic [1:0] MODE_MOD = 2'd1;
    localparam logic [1:0] MODE_BCD = 2'd2;

    localparam logic [NIBBLE_W-1:0] BCD_MAX_DIGIT = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the up/down ripple chain: steps when carry_in is high and
// reports carry (up) or borrow (down) to the next digit.
module bcd_digit
    import counter_pkg::*;
(
    input  logic [NIBBLE_W-1:0] digit,
    input  logic                up,
    input  logic                carry_in,
    output logic [NIBBLE_W-1:0] digit_next,
    output logic                carry_out
);

    always_comb begin
        digit_next = digit;
        carry_out  = 1'b0;
        if (carry_in) begin
            if (up) begin
                if (digit >= BCD_MAX_DIGIT) begin
                    digit_next = '0;
                    carry_out  = 1'b1;
                end else begin
                    digit_next = NIBBLE_W'(digit + NIBBLE_W'(1));
                end
            end else begin
                if (digit == '0) begin
                    digit_next = BCD_MAX_DIGIT;
                    carry_out  = 1'b1;
                end else begin
                    digit_next = NIBBLE_W'(digit - NIBBLE_W'(1));
                end
            end
        end
    end

endmodule

// File: rtl/updown_mode_counter.sv
// Up/down counter with hold, clipped parallel load and binary/modulo/BCD modes.
// Optional step prescaler built when COUNTER_PRESCALE_EN is defined.
module updown_mode_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             hold,
    input  logic             up,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] limit,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned DIGITS = WIDTH / NIBBLE_W;

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH == 0 || PRESCALE == 0) begin : g_cfg_err
        $fatal(1, "updown_mode_counter: WIDTH must be a non-zero multiple of 4 and PRESCALE >= 1");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] max_c;
    logic [WIDTH-1:0] clip_c;
    logic             over_c;
    logic             tick_c;
    logic [WIDTH-1:0] bcd_next_c;
    logic [DIGITS:0]  bcd_carry_c;

    // Per-mode maximum, out-of-range detect and load clipping
    always_comb begin
        max_c  = '1;
        over_c = 1'b0;
        clip_c = load_val;
        case (mode)
            MODE_MOD: begin
                max_c  = limit;
                over_c = (count_q > limit);
                clip_c = (load_val > limit) ? limit : load_val;
            end
            MODE_BCD: begin
                for (int i = 0; i < int'(DIGITS); i++) begin
                    max_c[i*NIBBLE_W +: NIBBLE_W] = BCD_MAX_DIGIT;
                    if (count_q[i*NIBBLE_W +: NIBBLE_W] > BCD_MAX_DIGIT) begin
                        over_c = 1'b1;
                    end
                    if (load_val[i*NIBBLE_W +: NIBBLE_W] > BCD_MAX_DIGIT) begin
                        clip_c[i*NIBBLE_W +: NIBBLE_W] = BCD_MAX_DIGIT;
                    end
                end
            end
            default: begin
                max_c  = '1;
                over_c = 1'b0;
                clip_c = load_val;
            end
        endcase
    end

    assign bcd_carry_c[0] = 1'b1;

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_bcd
        bcd_digit u_digit (
            .digit      (count_q[g*NIBBLE_W +: NIBBLE_W]),
            .up         (up),
            .carry_in   (bcd_carry_c[g]),
            .digit_next (bcd_next_c[g*NIBBLE_W +: NIBBLE_W]),
            .carry_out  (bcd_carry_c[g+1])
        );
    end

`ifdef COUNTER_PRESCALE_EN
    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0] presc_q, presc_d;

    assign tick_c = (presc_q == PS_W'(PRESCALE - 1));

    // Prescaler advances on en && !hold cycles; a load leaves it untouched
    always_comb begin
        presc_d = presc_q;
        if (!load && en && !hold) begin
            presc_d = tick_c ? '0 : PS_W'(presc_q + PS_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    assign tick_c = 1'b1;
`endif

    // Next count: load > hold > step; wrap flagged on every wraparound step
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q;
        if (load) begin
            count_d = clip_c;
        end else if (hold) begin
            count_d = count_q;
        end else if (en && tick_c) begin
            if (over_c) begin
                count_d = up ? '0 : max_c;
                wrap_d  = 1'b1;
            end else if (mode == MODE_BCD) begin
                count_d = bcd_next_c;
                wrap_d  = bcd_carry_c[DIGITS];
            end else if (up) begin
                if (count_q == max_c) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    count_d = max_c;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (wrap_d) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign ovf   = ovf_q;
    assign zero  = (count_q == '0);

endmodule
